// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
// uart_rx_os : oversampling UART receiver, majority-vote bit sampling,
//              parity / 1-2 stop bits / break, holding reg with valid-ack.
//              Optional rx_timeout output under macro UART_RX_TIMEOUT_EN.
// Revision   : 1.0
// ============================================================================
module uart_rx_os #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 rx_serial,
    input  logic [DIV_W-1:0]     cfg_div,
    input  logic                 cfg_parity_en,
    input  logic                 cfg_parity_odd,
    input  logic                 cfg_stop2,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_error,
    output logic                 parity_error,
    output logic                 break_detect,
    output logic                 overrun_error,
    output logic                 rx_busy
`ifdef UART_RX_TIMEOUT_EN
    ,
    output logic                 rx_timeout
`endif
);

    localparam int SCNT_W = $clog2(OVERSAMPLE);
    localparam int BCNT_W = $clog2(DATA_BITS + 1);
    localparam logic [SCNT_W-1:0] C_S0    = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] C_S1    = SCNT_W'(OVERSAMPLE / 2);
    localparam logic [SCNT_W-1:0] C_VOTE  = SCNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [SCNT_W-1:0] C_LAST  = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [BCNT_W-1:0] C_NBITS = BCNT_W'(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP1   = 3'd4,
        STOP2   = 3'd5,
        BRKWAIT = 3'd6
    } state_t;

    state_t r_state, w_next;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   rxs;
    logic [DIV_W-1:0]       r_div_cnt;
    logic [SCNT_W-1:0]      r_scnt;
    logic [BCNT_W-1:0]      r_bcnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_s0, r_s1;
    logic                   r_par_en, r_par_odd, r_stop2;
    logic                   r_par_bit, r_stop1_bad;
    logic                   w_tick, w_start, w_vote_pt, w_end, w_bit;
    logic                   w_complete, w_ferr, w_brk, w_perr, w_brk_cond;

    // Synchroniser resets to idle-high so reset release never looks like a start bit
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) r_sync <= '1;
        else          r_sync <= {r_sync[SYNC_STAGES-2:0], rx_serial};
    end
    assign rxs = r_sync[SYNC_STAGES-1];

    assign w_tick    = (r_div_cnt == '0);
    assign w_start   = (r_state == IDLE) && !rxs;
    assign w_vote_pt = w_tick && (r_scnt == C_VOTE);
    assign w_end     = w_tick && (r_scnt == C_LAST);
    assign w_bit     = (r_s0 & r_s1) | (r_s0 & rxs) | (r_s1 & rxs);

    // Reloading on start detection aligns the bit phase to the falling edge
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)                r_div_cnt <= '0;
        else if (w_start || w_tick)  r_div_cnt <= cfg_div;
        else                         r_div_cnt <= r_div_cnt - 1'b1;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)               r_scnt <= '0;
        else if (r_state == IDLE)   r_scnt <= '0;
        else if (w_tick)            r_scnt <= (r_scnt == C_LAST) ? '0 : r_scnt + 1'b1;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) r_state <= IDLE;
        else          r_state <= w_next;
    end

    assign w_brk_cond = (r_shift == '0) && !w_bit && (!r_par_en || !r_par_bit);
    assign w_perr     = r_par_en && ((^r_shift ^ r_par_bit) != r_par_odd);

    always_comb begin
        w_next     = r_state;
        w_complete = 1'b0;
        w_ferr     = 1'b0;
        w_brk      = 1'b0;
        case (r_state)
            IDLE:    if (!rxs) w_next = START;
            START: begin
                if (w_vote_pt && w_bit) w_next = IDLE;
                else if (w_end)         w_next = DATA;
            end
            DATA:    if (w_end && (r_bcnt == C_NBITS)) w_next = r_par_en ? PARITY : STOP1;
            PARITY:  if (w_end) w_next = STOP1;
            STOP1: begin
                if (w_vote_pt) begin
                    // A break completes at the first stop bit even in 2-stop mode
                    if (w_brk_cond) begin
                        w_complete = 1'b1;
                        w_ferr     = 1'b1;
                        w_brk      = 1'b1;
                        w_next     = BRKWAIT;
                    end else if (!r_stop2) begin
                        w_complete = 1'b1;
                        w_ferr     = !w_bit;
                        w_next     = IDLE;
                    end
                end else if (w_end && r_stop2) begin
                    w_next = STOP2;
                end
            end
            STOP2: begin
                if (w_vote_pt) begin
                    w_complete = 1'b1;
                    w_ferr     = r_stop1_bad | !w_bit;
                    w_next     = IDLE;
                end
            end
            BRKWAIT: if (rxs) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_par_en    <= 1'b0;
            r_par_odd   <= 1'b0;
            r_stop2     <= 1'b0;
            r_bcnt      <= '0;
            r_shift     <= '0;
            r_s0        <= 1'b0;
            r_s1        <= 1'b0;
            r_par_bit   <= 1'b0;
            r_stop1_bad <= 1'b0;
        end else begin
            if (w_start) begin
                r_par_en  <= cfg_parity_en;
                r_par_odd <= cfg_parity_odd;
                r_stop2   <= cfg_stop2;
                r_bcnt    <= '0;
            end
            if (w_tick && (r_scnt == C_S0)) r_s0 <= rxs;
            if (w_tick && (r_scnt == C_S1)) r_s1 <= rxs;
            if (w_vote_pt) begin
                case (r_state)
                    DATA: begin
                        r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                        r_bcnt  <= r_bcnt + 1'b1;
                    end
                    PARITY:  r_par_bit   <= w_bit;
                    STOP1:   r_stop1_bad <= !w_bit;
                    default: ;
                endcase
            end
        end
    end

    // An ack in the completion cycle frees the slot for the new character
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            frame_error   <= 1'b0;
            parity_error  <= 1'b0;
            break_detect  <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            if (w_complete && (!rx_valid || rx_ack)) begin
                rx_data      <= r_shift;
                frame_error  <= w_ferr;
                parity_error <= w_perr;
                break_detect <= w_brk;
                rx_valid     <= 1'b1;
            end else if (rx_ack && rx_valid) begin
                rx_valid     <= 1'b0;
            end
            if (rx_ack && rx_valid)            overrun_error <= 1'b0;
            else if (w_complete && rx_valid)   overrun_error <= 1'b1;
        end
    end

    assign rx_busy = (r_state != IDLE);

`ifdef UART_RX_TIMEOUT_EN
    localparam int TO_LIMIT = 4 * OVERSAMPLE * (DATA_BITS + 2);
    localparam int TO_W     = $clog2(TO_LIMIT + 1);
    localparam logic [TO_W-1:0] C_TO_LIMIT = TO_W'(TO_LIMIT);

    logic [TO_W-1:0] r_to_cnt;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_to_cnt   <= '0;
            rx_timeout <= 1'b0;
        end else begin
            if (w_start || rx_ack)
                r_to_cnt <= '0;
            else if (w_tick && (r_state == IDLE) && rx_valid && rxs && (r_to_cnt != C_TO_LIMIT))
                r_to_cnt <= r_to_cnt + 1'b1;
            if (rx_ack)                        rx_timeout <= 1'b0;
            else if (r_to_cnt == C_TO_LIMIT)   rx_timeout <= 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`default_nettype none
// tb_uart_rx_os : scenario tasks drive serial frames, push expected
// characters to a scoreboard and compare them when rx_valid rises.
module tb_uart_rx_os;

    localparam int DB = 8;
    localparam int DW = 16;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic          rx_serial = 1'b1;
    logic [DW-1:0] cfg_div = '0;
    logic          cfg_parity_en = 1'b0;
    logic          cfg_parity_odd = 1'b0;
    logic          cfg_stop2 = 1'b0;
    logic          rx_ack = 1'b0;
    logic [DB-1:0] rx_data;
    logic          rx_valid, frame_error, parity_error, break_detect, overrun_error, rx_busy;
`ifdef UART_RX_TIMEOUT_EN
    logic          rx_timeout;
`endif

    int n_cmp = 0;
    int n_err = 0;
    // entry = {data, frame_error, parity_error, break_detect}
    logic [10:0] sb[$];
    logic [10:0] exp_e;

    always #5 PCLK = ~PCLK;

    uart_rx_os #(.DATA_BITS(DB), .OVERSAMPLE(16), .DIV_W(DW), .SYNC_STAGES(2)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .rx_serial(rx_serial), .cfg_div(cfg_div),
        .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd), .cfg_stop2(cfg_stop2),
        .rx_ack(rx_ack), .rx_data(rx_data), .rx_valid(rx_valid), .frame_error(frame_error),
        .parity_error(parity_error), .break_detect(break_detect), .overrun_error(overrun_error),
        .rx_busy(rx_busy)
`ifdef UART_RX_TIMEOUT_EN
        , .rx_timeout(rx_timeout)
`endif
    );

    task automatic tick_n(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic drive_bit(input logic v, input int cpb, input int g_at, input int g_len);
        for (int c = 0; c < cpb; c++) begin
            rx_serial = (c >= g_at && c < g_at + g_len) ? 1'b0 : v;
            @(negedge PCLK);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_en, input logic par_bit,
                              input bit two_stop, input logic stop2v, input int cpb, input int gbit);
        drive_bit(1'b0, cpb, 0, 0);
        for (int i = 0; i < DB; i++)
            drive_bit(d[i], cpb, (i == gbit) ? cpb / 2 : 0, (i == gbit) ? cpb / 16 : 0);
        if (par_en) drive_bit(par_bit, cpb, 0, 0);
        drive_bit(1'b1, cpb, 0, 0);
        if (two_stop) drive_bit(stop2v, cpb, 0, 0);
        rx_serial = 1'b1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (rx_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge PCLK);
        end
    endtask

    task automatic do_ack;
        rx_ack = 1'b1;
        @(negedge PCLK);
        rx_ack = 1'b0;
    endtask

    task automatic test_reset;
        PRESETn = 1'b0;
        tick_n(3);
        n_cmp++;
        if ({rx_data, rx_valid, frame_error, parity_error, break_detect, overrun_error, rx_busy} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h required 0",
                     {rx_data, rx_valid, frame_error, parity_error, break_detect, overrun_error, rx_busy});
        end
        PRESETn = 1'b1;
        tick_n(5);
        n_cmp++;
        if (rx_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_false_start: rx_busy=%b required 0", rx_busy);
        end
    endtask

    task automatic test_basic;
        bit ok;
        cfg_div = 0; cfg_parity_en = 0; cfg_stop2 = 0;
        sb.push_back({8'hA5, 3'b000});
        send_frame(8'hA5, 0, 0, 0, 1, 16, -1);
        wait_valid(ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL basic_valid: rx_valid=0 required 1"); end
        exp_e = sb.pop_front();
        n_cmp++;
        if ({rx_data, frame_error, parity_error, break_detect} !== exp_e) begin
            n_err++;
            $display("FAIL basic_char: got %h required %h", {rx_data, frame_error, parity_error, break_detect}, exp_e);
        end
        do_ack;
        n_cmp++;
        if (rx_valid !== 1'b0) begin n_err++; $display("FAIL basic_ack: rx_valid=%b required 0", rx_valid); end
    endtask

    task automatic test_parity;
        bit ok;
        cfg_parity_en = 1;
        for (int k = 0; k < 2; k++) begin
            cfg_parity_odd = (k == 1);
            sb.push_back({8'h07, 1'b0, (k == 0), 1'b0});
            send_frame(8'h07, 1, 1'b0, 0, 1, 16, -1);
            wait_valid(ok);
            exp_e = sb.pop_front();
            n_cmp++;
            if (!ok || {rx_data, frame_error, parity_error, break_detect} !== exp_e) begin
                n_err++;
                $display("FAIL parity_char%0d: got %h valid %b required %h", k,
                         {rx_data, frame_error, parity_error, break_detect}, rx_valid, exp_e);
            end
            do_ack;
        end
        cfg_parity_en = 0; cfg_parity_odd = 0;
    endtask

    task automatic test_glitch;
        bit ok;
        cfg_div = 3;
        rx_serial = 1'b0;
        tick_n(15);
        n_cmp++;
        if (rx_busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy: rx_busy=%b required 1", rx_busy); end
        tick_n(5);
        rx_serial = 1'b1;
        tick_n(150);
        n_cmp++;
        if ({rx_busy, rx_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL glitch_reject: busy/valid=%b required 00", {rx_busy, rx_valid});
        end
        sb.push_back({8'h3C, 3'b000});
        send_frame(8'h3C, 0, 0, 0, 1, 64, 2);
        wait_valid(ok);
        exp_e = sb.pop_front();
        n_cmp++;
        if (!ok || {rx_data, frame_error, parity_error, break_detect} !== exp_e) begin
            n_err++;
            $display("FAIL glitch_vote: got %h required %h", {rx_data, frame_error, parity_error, break_detect}, exp_e);
        end
        do_ack;
        cfg_div = 0;
    endtask

    task automatic test_overrun;
        sb.push_back({8'h11, 3'b000});
        send_frame(8'h11, 0, 0, 0, 1, 16, -1);
        send_frame(8'h22, 0, 0, 0, 1, 16, -1);
        tick_n(5);
        exp_e = sb.pop_front();
        n_cmp++;
        if ({rx_valid, rx_data, frame_error, parity_error, break_detect} !== {1'b1, exp_e}) begin
            n_err++;
            $display("FAIL overrun_keep: got %h required %h", {rx_valid, rx_data, frame_error, parity_error, break_detect}, {1'b1, exp_e});
        end
        n_cmp++;
        if (overrun_error !== 1'b1) begin n_err++; $display("FAIL overrun_flag: got %b required 1", overrun_error); end
        do_ack;
        n_cmp++;
        if ({rx_valid, overrun_error} !== 2'b00) begin
            n_err++;
            $display("FAIL overrun_ack: valid/ovr=%b required 00", {rx_valid, overrun_error});
        end
    endtask

    task automatic test_break;
        bit ok;
        cfg_stop2 = 1;
        sb.push_back({8'h00, 3'b101});
        rx_serial = 1'b0;
        tick_n(12 * 16);
        exp_e = sb.pop_front();
        n_cmp++;
        if ({rx_valid, rx_data, frame_error, parity_error, break_detect} !== {1'b1, exp_e}) begin
            n_err++;
            $display("FAIL break_char: got %h required %h", {rx_valid, rx_data, frame_error, parity_error, break_detect}, {1'b1, exp_e});
        end
        n_cmp++;
        if (rx_busy !== 1'b1) begin n_err++; $display("FAIL break_busy: rx_busy=%b required 1", rx_busy); end
        rx_serial = 1'b1;
        tick_n(5);
        n_cmp++;
        if (rx_busy !== 1'b0) begin n_err++; $display("FAIL break_release: rx_busy=%b required 0", rx_busy); end
        do_ack;
        sb.push_back({8'h55, 3'b100});
        send_frame(8'h55, 0, 0, 1, 1'b0, 16, -1);
        wait_valid(ok);
        exp_e = sb.pop_front();
        n_cmp++;
        if (!ok || {rx_data, frame_error, parity_error, break_detect} !== exp_e) begin
            n_err++;
            $display("FAIL stop2_ferr: got %h required %h", {rx_data, frame_error, parity_error, break_detect}, exp_e);
        end
        tick_n(40);
        do_ack;
        cfg_stop2 = 0;
    endtask

    task automatic test_back_to_back;
        bit ok;
        sb.push_back({8'h81, 3'b000});
        sb.push_back({8'h7E, 3'b000});
        fork
            begin
                send_frame(8'h81, 0, 0, 0, 1, 16, -1);
                send_frame(8'h7E, 0, 0, 0, 1, 16, -1);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    wait_valid(ok);
                    exp_e = sb.pop_front();
                    n_cmp++;
                    if (!ok || {rx_data, frame_error, parity_error, break_detect} !== exp_e) begin
                        n_err++;
                        $display("FAIL b2b_char%0d: got %h valid %b required %h", k,
                                 {rx_data, frame_error, parity_error, break_detect}, rx_valid, exp_e);
                    end
                    do_ack;
                end
            end
        join
        n_cmp++;
        if (overrun_error !== 1'b0) begin n_err++; $display("FAIL b2b_overrun: got %b required 0", overrun_error); end
    endtask

    task automatic test_reset_mid;
        send_frame(8'h5A, 0, 0, 0, 1, 16, -1);
        tick_n(3);
        n_cmp++;
        if (rx_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_valid: got %b required 1", rx_valid); end
        drive_bit(1'b0, 16, 0, 0);
        drive_bit(1'b0, 16, 0, 0);
        drive_bit(1'b1, 16, 0, 0);
        n_cmp++;
        if (rx_busy !== 1'b1) begin n_err++; $display("FAIL rstmid_busy: got %b required 1", rx_busy); end
        PRESETn = 1'b0;
        @(negedge PCLK);
        n_cmp++;
        if ({rx_data, rx_valid, frame_error, parity_error, break_detect, overrun_error, rx_busy} !== '0) begin
            n_err++;
            $display("FAIL rstmid_outputs: got %h required 0",
                     {rx_data, rx_valid, frame_error, parity_error, break_detect, overrun_error, rx_busy});
        end
        rx_serial = 1'b1;
        PRESETn = 1'b1;
        tick_n(300);
        n_cmp++;
        if ({rx_valid, rx_busy} !== 2'b00) begin
            n_err++;
            $display("FAIL rstmid_nochar: valid/busy=%b required 00", {rx_valid, rx_busy});
        end
    endtask

`ifdef UART_RX_TIMEOUT_EN
    task automatic test_timeout;
        bit ok;
        send_frame(8'h01, 0, 0, 0, 1, 16, -1);
        wait_valid(ok);
        n_cmp++;
        if (!ok || rx_data !== 8'h01) begin n_err++; $display("FAIL to_char: got %h required 01", rx_data); end
        tick_n(600);
        n_cmp++;
        if (rx_timeout !== 1'b0) begin n_err++; $display("FAIL to_early: got %b required 0", rx_timeout); end
        tick_n(80);
        n_cmp++;
        if (rx_timeout !== 1'b1) begin n_err++; $display("FAIL to_set: got %b required 1", rx_timeout); end
        do_ack;
        n_cmp++;
        if (rx_timeout !== 1'b0) begin n_err++; $display("FAIL to_ack: got %b required 0", rx_timeout); end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_parity;
        test_glitch;
        test_overrun;
        test_break;
        test_back_to_back;
        test_reset_mid;
`ifdef UART_RX_TIMEOUT_EN
        test_timeout;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Next-generation UART receiver for the APB UART IP.
- Uses a runtime-programmable baud divisor and an oversampling bit engine with majority-vote sampling.
- Adds optional parity, 1 or 2 stop bits, break detection, and a holding register with a valid/ack handshake and overrun reporting.
- Sits between the pad-side rx_serial line and the APB register block, which drives the cfg_* inputs and pops data with rx_ack.

Parameters:
- DATA_BITS, 8, data bits per character (5..9).
- OVERSAMPLE, 16, ticks per bit. Must be an even value ≥ 8.
- DIV_W, 16, width of the baud divisor input.
- SYNC_STAGES, 2, flops in the rx_serial synchroniser (≥ 2).

Ports:
- PCLK input 1: system clock.
- PRESETn input 1: reset, asynchronous, active-low.
- rx_serial input 1: asynchronous serial line, idle high.
- cfg_div input DIV_W: oversample tick period minus 1, in PCLK cycles.
- cfg_parity_en input 1: 1 = a parity bit follows the data bits.
- cfg_parity_odd input 1: 1 = odd parity, 0 = even parity.
- cfg_stop2 input 1: 1 = two stop bits expected.
- rx_ack input 1: pops the holding register.
- rx_data output DATA_BITS: held character, LSB = first bit received.
- rx_valid output 1: holding register full.
- frame_error output 1: status of the held character; stop bit sampled 0.
- parity_error output 1: status of the held character; parity mismatch.
- break_detect output 1: status of the held character; break condition.
- overrun_error output 1: sticky; a character was lost.
- rx_busy output 1: a frame is in progress.

Behaviour:
- Reset: every output is 0. FSM = IDLE, counters = 0, synchroniser flops = 1 (no false start bit out of reset). Reset mid-frame discards the frame immediately.
- Synchroniser:
  - rx_serial passes through SYNC_STAGES flops; the FSM only sees rxs.
  - Input-to-rxs latency is SYNC_STAGES cycles.
- Tick generator:
  - Free-running down-counter reloaded with cfg_div; emits a 1-cycle tick on reaching 0.
  - cfg_div = 0 gives a tick every cycle.
  - The counter is reloaded on start detection so bit phase aligns to the falling edge.
- Sample counter:
  - Counts ticks 0..OVERSAMPLE-1 within each bit.
  - Samples are captured at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - The bit value is the 2-of-3 majority, resolved at tick OVERSAMPLE/2+1.
- Config latch:
  - cfg_parity_en, cfg_parity_odd and cfg_stop2 are captured at start detection.
  - cfg_div is sampled live.
  - Mid-frame changes to the parity/stop inputs do not affect the current frame.
- FSM states:
  - IDLE: rx_busy = 0. On rxs = 0, go to START and set rx_busy = 1.
  - START: at the vote point, majority 1 returns to IDLE (glitch rejected, no status change); majority 0 goes to DATA at the end of the bit.
  - DATA: shift DATA_BITS voted bits, LSB first. After the last bit go to PARITY if parity is enabled, else STOP1.
  - PARITY: compute the XOR of the data bits and the parity bit. Error if the result is ≠ cfg_parity_odd.
  - STOP1: vote the stop bit. If cfg_stop2 is set, go to STOP2; otherwise complete the frame at the STOP1 vote point, not at the end of the bit.
  - STOP2: a second stop bit is checked the same way. frame_error is set if either stop bit is 0.
  - BRKWAIT: entered when break_detect is set. Stays here with rx_busy = 1 until rxs = 1 is seen, then returns to IDLE.
- Completion, one cycle after the final vote:
  - If rx_valid = 0: load rx_data, frame_error, parity_error and break_detect together and set rx_valid = 1.
  - If rx_valid = 1: keep the old character and status, set overrun_error = 1, drop the new character.
  - After completion the FSM returns to IDLE, or to BRKWAIT on a break.
- Break condition:
  - All data bits 0, the parity bit (if enabled) 0, and the first stop bit 0.
  - A break sets break_detect = 1 and frame_error = 1.
- Handshake:
  - rx_ack while rx_valid = 1 clears rx_valid and clears overrun_error in the next cycle.
  - rx_ack while rx_valid = 0 is ignored.
  - If rx_ack and a completion fall in the same cycle, the ack pops the old character, the new one is loaded, rx_valid stays 1, and no overrun is flagged.
- A new start bit is accepted one tick after returning to IDLE (back-to-back frames).

Optional Feature:
- Macro: UART_RX_TIMEOUT_EN.
- When defined:
  - Adds output rx_timeout (1 bit, reset 0).
  - A tick counter runs while FSM = IDLE, rx_valid = 1 and rxs = 1, and resets on any start detection or rx_ack.
  - When the count reaches 4*OVERSAMPLE*(DATA_BITS+2) ticks, rx_timeout = 1 and holds until rx_ack.
- When not defined: no port, no counter, no logic.

Test Plan:
- Basic frame: OVERSAMPLE = 16, cfg_div = 0, 8N1, send 0xA5 at 16 clocks/bit → rx_valid rises with rx_data = 0xA5 and all error flags 0; rx_ack clears rx_valid on the next cycle.
- Parity: 8E1, send 0x07 with parity bit 0 → parity_error = 1, rx_data = 0x07. Same frame with cfg_parity_odd = 1 and parity bit 0 → parity_error = 0.
- Glitch rejection: cfg_div = 3, drive a 20-cycle low pulse on the idle line → FSM returns to IDLE with no rx_valid. Then send 0x3C with a single-tick low glitch inside a high data bit → rx_data = 0x3C via the majority vote.
- Overrun: send 0x11 then 0x22 without rx_ack → rx_data = 0x11, overrun_error = 1. rx_ack → rx_valid = 0, overrun_error = 0.
- Break and two stop bits: 8N2, hold the line low for 12 bit times → break_detect = 1, frame_error = 1, rx_busy held until the line returns high. Then send 0x55 with the second stop bit 0 → frame_error = 1, break_detect = 0.
- Reset and timeout: assert PRESETn mid-DATA → all outputs 0 and no character delivered. With UART_RX_TIMEOUT_EN defined, send 0x01, leave it un-acked and the line idle → rx_timeout = 1 after 640 ticks.
